// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
package sccb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID,
      ST_SUB,
      ST_DATA,
      ST_RD,
      ST_WAIT_STOP
   } state_e;

   // 8 data bits plus the trailing don't-care / ACK bit
   localparam int unsigned BITS_PER_PHASE = 9;
   localparam logic [7:0]  OV7670_ID      = 8'h42;

endpackage

// File: rtl/sccb_responder_if.sv
// SCCB bus pins and the single-cycle register port of the responder.
interface sccb_responder_if;
   logic       sioc_i;
   logic       siod_i;
   logic       siod_oe_o;
   logic       reg_we_o;
   logic       reg_re_o;
   logic [7:0] reg_addr_o;
   logic [7:0] reg_wdata_o;
   logic [7:0] reg_rdata_i;
   logic       busy_o;

   modport slave (
      input  sioc_i, siod_i, reg_rdata_i,
      output siod_oe_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, busy_o
   );

   modport master (
      output sioc_i, siod_i, reg_rdata_i,
      input  siod_oe_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, busy_o
   );
endinterface

// File: rtl/sccb_bus_sync.sv
// Synchronizes SIOC/SIOD into clk_i and detects clock edges, START and STOP.
module sccb_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sioc_i,
   input  logic siod_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], sioc_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], siod_i};
      scl_prev_d = scl_sync_q[SYNC_STAGES-1];
      sda_prev_d = sda_sync_q[SYNC_STAGES-1];
   end

   // Reset to the idle-bus level so no edge is seen when reset drops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   assign scl       = scl_sync_q[SYNC_STAGES-1];
   assign sda       = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl & ~scl_prev_q;
   assign scl_fall  = ~scl & scl_prev_q;
   assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
   assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target decoding 3-phase writes and 2-phase write + 2-phase read.
// Define SCCB_RESPONDER_ACK_EN to pull SIOD low in the 9th bit of matched phases.
module sccb_responder
   import sccb_pkg::*;
#(
   parameter logic [7:0]  DEV_ID      = OV7670_ID,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   sccb_responder_if.slave bus
);

   localparam logic [3:0] PHASE_BITS = 4'(BITS_PER_PHASE);

   logic scl_rise, scl_fall, start_det, stop_det, sda;

   sccb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .sioc_i    (bus.sioc_i),
      .siod_i    (bus.siod_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda       (sda)
   );

   state_e     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       we_q, we_d;
   logic       re_q, re_d;
   logic       rd_load_q, rd_load_d;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;

   logic       phase_end, id_match;
   logic [2:0] rd_idx;

   assign phase_end = scl_fall && (bit_cnt_q == PHASE_BITS);
   assign id_match  = (shift_q[7:1] == DEV_ID[7:1]);
   assign rd_idx    = 3'(4'd7 - bit_cnt_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         rd_load_q <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         we_q      <= we_d;
         re_q      <= re_d;
         rd_load_q <= rd_load_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ID:   if (phase_end) state_d = !id_match ? ST_WAIT_STOP :
                                           shift_q[0] ? ST_RD : ST_SUB;
         ST_SUB:  if (phase_end) state_d = ST_DATA;
         ST_DATA: if (phase_end) state_d = ST_WAIT_STOP;
         ST_RD:   if (scl_fall && bit_cnt_q == 4'd8) state_d = ST_WAIT_STOP;
         default: state_d = state_q;
      endcase
      if (start_det) state_d = ST_ID;
      if (stop_det)  state_d = ST_IDLE;
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      rd_load_d = 1'b0;
      oe_d      = oe_q;
      busy_d    = busy_q;
      unique case (state_q)
         ST_ID, ST_SUB, ST_DATA: begin
            if (scl_rise && bit_cnt_q < PHASE_BITS) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q < PHASE_BITS - 4'd1) shift_d = {shift_q[6:0], sda};
            end
`ifdef SCCB_RESPONDER_ACK_EN
            // SUB/DATA are only reachable after a matching ID
            if (scl_fall && bit_cnt_q == PHASE_BITS - 4'd1)
               oe_d = (state_q != ST_ID) || id_match;
`endif
            if (phase_end) begin
               bit_cnt_d = '0;
               oe_d      = 1'b0;
               if (state_q == ST_SUB) addr_d = shift_q;
               if (state_q == ST_DATA) begin
                  wdata_d = shift_q;
                  we_d    = 1'b1;
               end
               if (state_q == ST_ID) re_d = id_match && shift_q[0];
            end
         end
         ST_RD: begin
            // Read data arrives the cycle after the strobe; bit 7 goes out as soon as it lands
            rd_load_d = re_q;
            if (rd_load_q) begin
               rdata_d = bus.reg_rdata_i;
               oe_d    = ~bus.reg_rdata_i[7];
            end
            if (scl_rise && bit_cnt_q < PHASE_BITS) bit_cnt_d = bit_cnt_q + 4'd1;
            if (scl_fall) begin
               if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) oe_d = ~rdata_q[rd_idx];
               else if (bit_cnt_q == 4'd8)                 oe_d = 1'b0;
            end
         end
         default: oe_d = 1'b0;
      endcase
      if (start_det) begin
         bit_cnt_d = '0;
         oe_d      = 1'b0;
         busy_d    = 1'b1;
      end
      if (stop_det) begin
         bit_cnt_d = '0;
         oe_d      = 1'b0;
         busy_d    = 1'b0;
      end
   end

   assign bus.siod_oe_o   = oe_q;
   assign bus.reg_we_o    = we_q;
   assign bus.reg_re_o    = re_q;
   assign bus.reg_addr_o  = addr_q;
   assign bus.reg_wdata_o = wdata_q;
   assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master on a wired-AND SIOD.
module tb_sccb_responder;

   localparam int Q = 10;
`ifdef SCCB_RESPONDER_ACK_EN
   localparam bit ACK_EN = 1'b1;
`else
   localparam bit ACK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] rdata_m = 8'h00;

   int chk = 0;
   int err = 0;

   int         we_cnt = 0, re_cnt = 0, oe_cnt = 0;
   logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;

   sccb_responder_if bus_if();

   assign bus_if.sioc_i      = scl_m;
   assign bus_if.siod_i      = sda_m & ~bus_if.siod_oe_o;
   assign bus_if.reg_rdata_i = rdata_m;

   sccb_responder #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus_if.reg_we_o) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= bus_if.reg_addr_o;
         we_data <= bus_if.reg_wdata_o;
      end
      if (bus_if.reg_re_o) begin
         re_cnt  <= re_cnt + 1;
         re_addr <= bus_if.reg_addr_o;
      end
      if (bus_if.siod_oe_o) oe_cnt <= oe_cnt + 1;
   end

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wq(Q);
         scl_m = 1'b1; wq(2 * Q);
         scl_m = 1'b0; wq(Q);
      end
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      ack = bus_if.siod_oe_o;
      wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic recv_bit(output logic d, output logic oe);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      d  = bus_if.siod_i;
      oe = bus_if.siod_oe_o;
      wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic recv_byte(output logic [7:0] d, output logic [7:0] pat, output logic na_oe);
      logic dd, nd;
      for (int i = 7; i >= 0; i--) recv_bit(d[i], pat[i]);
      recv_bit(dd, nd);
      na_oe = nd;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wq(4);
      chk++; if (bus_if.siod_oe_o !== 1'b0) begin err++; $display("FAIL reset_oe: got %b want 0", bus_if.siod_oe_o); end
      chk++; if (bus_if.reg_we_o !== 1'b0) begin err++; $display("FAIL reset_we: got %b want 0", bus_if.reg_we_o); end
      chk++; if (bus_if.reg_re_o !== 1'b0) begin err++; $display("FAIL reset_re: got %b want 0", bus_if.reg_re_o); end
      chk++; if (bus_if.reg_addr_o !== 8'h00) begin err++; $display("FAIL reset_addr: got %h want 00", bus_if.reg_addr_o); end
      chk++; if (bus_if.reg_wdata_o !== 8'h00) begin err++; $display("FAIL reset_wdata: got %h want 00", bus_if.reg_wdata_o); end
      chk++; if (bus_if.busy_o !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", bus_if.busy_o); end
      rst = 1'b0;
      wq(Q);
   endtask

   task automatic test_read_default();
      logic a; logic [7:0] d, p; logic na; int re0;
      re0 = re_cnt;
      rdata_m = 8'h5A;
      bus_start();
      send_byte(8'h43, a);
      recv_byte(d, p, na);
      bus_stop();
      chk++; if (re_cnt - re0 !== 1) begin err++; $display("FAIL rd0_re_count: got %0d want 1", re_cnt - re0); end
      chk++; if (re_addr !== 8'h00) begin err++; $display("FAIL rd0_addr: got %h want 00", re_addr); end
      chk++; if (d !== 8'h5A) begin err++; $display("FAIL rd0_data: got %h want 5a", d); end
      chk++; if (p !== 8'hA5) begin err++; $display("FAIL rd0_oe_pattern: got %h want a5", p); end
      chk++; if (na !== 1'b0) begin err++; $display("FAIL rd0_na_release: got %b want 0", na); end
   endtask

   task automatic test_write3();
      logic [2:0] acks; int we0, re0;
      we0 = we_cnt; re0 = re_cnt;
      bus_start();
      chk++; if (bus_if.busy_o !== 1'b1) begin err++; $display("FAIL wr3_busy_start: got %b want 1", bus_if.busy_o); end
      send_byte(8'h42, acks[2]);
      send_byte(8'h12, acks[1]);
      send_byte(8'h80, acks[0]);
      chk++; if (bus_if.busy_o !== 1'b1) begin err++; $display("FAIL wr3_busy_mid: got %b want 1", bus_if.busy_o); end
      bus_stop();
      chk++; if (bus_if.busy_o !== 1'b0) begin err++; $display("FAIL wr3_busy_stop: got %b want 0", bus_if.busy_o); end
      chk++; if (we_cnt - we0 !== 1) begin err++; $display("FAIL wr3_we_count: got %0d want 1", we_cnt - we0); end
      chk++; if (we_addr !== 8'h12) begin err++; $display("FAIL wr3_addr: got %h want 12", we_addr); end
      chk++; if (we_data !== 8'h80) begin err++; $display("FAIL wr3_data: got %h want 80", we_data); end
      chk++; if (re_cnt - re0 !== 0) begin err++; $display("FAIL wr3_re_count: got %0d want 0", re_cnt - re0); end
      chk++; if (acks !== {3{ACK_EN}}) begin err++; $display("FAIL wr3_acks: got %b want %b", acks, {3{ACK_EN}}); end
   endtask

   task automatic test_write2_read();
      logic a; logic [7:0] d, p; logic na; int we0, re0;
      we0 = we_cnt; re0 = re_cnt;
      rdata_m = 8'h76;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h0A, a);
      bus_stop();
      chk++; if (we_cnt - we0 !== 0) begin err++; $display("FAIL wr2_we_count: got %0d want 0", we_cnt - we0); end
      chk++; if (bus_if.reg_addr_o !== 8'h0A) begin err++; $display("FAIL wr2_addr: got %h want 0a", bus_if.reg_addr_o); end
      bus_start();
      send_byte(8'h43, a);
      recv_byte(d, p, na);
      bus_stop();
      chk++; if (re_cnt - re0 !== 1) begin err++; $display("FAIL rd_re_count: got %0d want 1", re_cnt - re0); end
      chk++; if (re_addr !== 8'h0A) begin err++; $display("FAIL rd_addr: got %h want 0a", re_addr); end
      chk++; if (p !== 8'h89) begin err++; $display("FAIL rd_oe_pattern: got %b want 10001001", p); end
      chk++; if (d !== 8'h76) begin err++; $display("FAIL rd_data: got %h want 76", d); end
      chk++; if (na !== 1'b0) begin err++; $display("FAIL rd_na_release: got %b want 0", na); end
   endtask

   task automatic test_wrong_id();
      logic [2:0] acks; logic a; int we0, re0, oe0;
      we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt;
      bus_start();
      send_byte(8'h60, acks[2]);
      send_byte(8'h12, acks[1]);
      send_byte(8'h80, acks[0]);
      bus_stop();
      chk++; if (we_cnt - we0 !== 0) begin err++; $display("FAIL id60_we_count: got %0d want 0", we_cnt - we0); end
      chk++; if (re_cnt - re0 !== 0) begin err++; $display("FAIL id60_re_count: got %0d want 0", re_cnt - re0); end
      chk++; if (oe_cnt - oe0 !== 0) begin err++; $display("FAIL id60_oe_cycles: got %0d want 0", oe_cnt - oe0); end
      chk++; if (acks !== 3'b000) begin err++; $display("FAIL id60_acks: got %b want 000", acks); end
      we0 = we_cnt;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h05, a);
      send_byte(8'h11, a);
      bus_stop();
      chk++; if (we_cnt - we0 !== 1) begin err++; $display("FAIL after60_we_count: got %0d want 1", we_cnt - we0); end
      chk++; if (we_addr !== 8'h05 || we_data !== 8'h11) begin err++; $display("FAIL after60_write: got %h/%h want 05/11", we_addr, we_data); end
   endtask

   task automatic test_rep_start();
      logic a; logic [7:0] d, p; logic na; int we0, re0;
      we0 = we_cnt; re0 = re_cnt;
      rdata_m = 8'hC3;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h0A, a);
      bus_start();
      send_byte(8'h43, a);
      recv_byte(d, p, na);
      bus_stop();
      chk++; if (we_cnt - we0 !== 0) begin err++; $display("FAIL sr_we_count: got %0d want 0", we_cnt - we0); end
      chk++; if (re_cnt - re0 !== 1) begin err++; $display("FAIL sr_re_count: got %0d want 1", re_cnt - re0); end
      chk++; if (re_addr !== 8'h0A) begin err++; $display("FAIL sr_addr: got %h want 0a", re_addr); end
      chk++; if (d !== 8'hC3) begin err++; $display("FAIL sr_data: got %h want c3", d); end
   endtask

   task automatic test_reset_mid_read();
      logic a, d0, p0; int we0;
      rdata_m = 8'h00;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h33, a);
      bus_start();
      send_byte(8'h43, a);
      recv_bit(d0, p0);
      recv_bit(d0, p0);
      wq(Q);
      chk++; if (bus_if.siod_oe_o !== 1'b1) begin err++; $display("FAIL mid_read_driving: got %b want 1", bus_if.siod_oe_o); end
      rst = 1'b1;
      wq(1);
      chk++; if (bus_if.siod_oe_o !== 1'b0) begin err++; $display("FAIL mid_rst_oe: got %b want 0", bus_if.siod_oe_o); end
      chk++; if (bus_if.reg_addr_o !== 8'h00 || bus_if.reg_wdata_o !== 8'h00) begin err++; $display("FAIL mid_rst_regs: got %h/%h want 00/00", bus_if.reg_addr_o, bus_if.reg_wdata_o); end
      chk++; if (bus_if.busy_o !== 1'b0 || bus_if.reg_we_o !== 1'b0 || bus_if.reg_re_o !== 1'b0) begin err++; $display("FAIL mid_rst_ctl: got busy=%b we=%b re=%b want 0", bus_if.busy_o, bus_if.reg_we_o, bus_if.reg_re_o); end
      rst = 1'b0;
      wq(2);
      bus_stop();
      we0 = we_cnt;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h07, a);
      send_byte(8'h99, a);
      bus_stop();
      chk++; if (we_cnt - we0 !== 1) begin err++; $display("FAIL post_rst_we_count: got %0d want 1", we_cnt - we0); end
      chk++; if (we_addr !== 8'h07 || we_data !== 8'h99) begin err++; $display("FAIL post_rst_write: got %h/%h want 07/99", we_addr, we_data); end
   endtask

   initial begin
      test_reset();
      test_read_default();
      test_write3();
      test_write2_read();
      test_wrong_id();
      test_rep_start();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
